// File: rtl/servo_pkg.sv
// Shared constants and the slew helper for the servo pulse generator.
package servo_pkg;

  localparam int BASE_COUNT_DEF = 50000;
  localparam int MAX_OFFSET_DEF = 200000;
  localparam int STEP_DEF       = 8;
  localparam int FRAME_LEN      = 2000000;
  localparam int POS_W          = 20;
  localparam int CNT_W          = 28;

  // One slew step toward tgt; lands exactly on tgt when closer than step.
  function automatic logic [POS_W-1:0] slew_step(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W-1:0] tgt,
                                                 input logic [POS_W-1:0] step);
    logic [POS_W-1:0] r;
    r = pos;
    if (pos < tgt) begin
      r = ((tgt - pos) < step) ? tgt : pos + step;
    end else if (pos > tgt) begin
      r = ((pos - tgt) < step) ? tgt : pos - step;
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_debounce_filter.sv
// Switch debounce: output follows the input only after DB_SAMPLES consecutive
// sample ticks disagree with the current output.
module sw_debounce_filter #(
  parameter int DB_SAMPLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic SAMPLE_TICK,
  input  logic IN,
  output logic OUT
);

  localparam int CW = $clog2(DB_SAMPLES + 1);

  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (SAMPLE_TICK) begin
      if (IN != out_q) begin
        if (cnt_q == CW'(DB_SAMPLES - 1)) begin
          out_d = IN;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM: slews a position toward a clamped target and emits a pulse of
// BASE_COUNT+POS cycles per frame. Define SERVO_DEBOUNCE_EN to debounce EN.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int BASE_COUNT = BASE_COUNT_DEF,
  parameter int MAX_OFFSET = MAX_OFFSET_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int DB_SAMPLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] COUNT,
  input  logic             SLK,
  input  logic             SCLK,
  input  logic             EN,
  input  logic [POS_W-1:0] DESIRED,
  output logic             PWM,
  output logic             FLAG
);

  localparam logic [POS_W-1:0] MAX_L  = POS_W'(MAX_OFFSET);
  localparam logic [POS_W-1:0] STEP_L = POS_W'(STEP);
  localparam logic [31:0]      BASE_L = 32'(BASE_COUNT);

  logic             en_meta_q, en_sync_q;
  logic             slk_q;
  logic             slk_tick;
  logic             en_eff;
  logic [POS_W-1:0] target;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pwm_q, pwm_d;
  logic             flag_q, flag_d;

`ifdef SERVO_DEBOUNCE_EN
  logic sclk_q;
  logic sclk_tick;
  logic en_db;

  assign sclk_tick = SCLK & ~sclk_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sclk_q <= 1'b0;
    else     sclk_q <= SCLK;
  end

  sw_debounce_filter #(.DB_SAMPLES(DB_SAMPLES)) u_debounce (
    .CLK        (CLK),
    .RST        (RST),
    .SAMPLE_TICK(sclk_tick),
    .IN         (en_sync_q),
    .OUT        (en_db)
  );

  assign en_eff = en_db;
`else
  logic unused_sclk;
  assign unused_sclk = SCLK;
  assign en_eff      = en_sync_q;
`endif

  assign slk_tick = SLK & ~slk_q;
  assign target   = (DESIRED > MAX_L) ? MAX_L : DESIRED;

  always_comb begin
    pos_d = pos_q;
    if (slk_tick && en_eff) pos_d = slew_step(pos_q, target, STEP_L);
    // 32-bit compare so BASE_COUNT + POS can never wrap.
    pwm_d  = en_eff && ({{(32-CNT_W){1'b0}}, COUNT} < (BASE_L + {{(32-POS_W){1'b0}}, pos_q}));
    flag_d = (pos_q == target);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
      slk_q     <= 1'b0;
      pos_q     <= '0;
      pwm_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      en_meta_q <= EN;
      en_sync_q <= en_meta_q;
      slk_q     <= SLK;
      pos_q     <= pos_d;
      pwm_q     <= pwm_d;
      flag_q    <= flag_d;
    end
  end

  assign PWM  = pwm_q;
  assign FLAG = flag_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Directed + randomized bench for servo_pwm with a scaled-down frame and a
// behavioural position model; handles both enable builds.
module tb_servo_pwm;

  localparam int BASE  = 20;
  localparam int MAXO  = 200;
  localparam int STEP  = 8;
  localparam int DBS   = 4;
  localparam int FRAME = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] count;
  logic        slk, sclk, en;
  logic [19:0] desired;
  logic        pwm, flag;

  int errors = 0;
  int checks = 0;
  int model_pos = 0;
  bit model_en  = 1'b0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  servo_pwm #(
    .BASE_COUNT(BASE),
    .MAX_OFFSET(MAXO),
    .STEP      (STEP),
    .DB_SAMPLES(DBS)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .COUNT  (count),
    .SLK    (slk),
    .SCLK   (sclk),
    .EN     (en),
    .DESIRED(desired),
    .PWM    (pwm),
    .FLAG   (flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clock/counter driver: inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      count = (count == 28'(FRAME - 1)) ? 28'd0 : count + 28'd1;
    end
  endtask

  function automatic int model_target();
    return (int'(desired) > MAXO) ? MAXO : int'(desired);
  endfunction

  task automatic model_slew();
    int tgt, d;
    tgt = model_target();
    d   = tgt - model_pos;
    if (!model_en)      return;
    if (d > STEP)       model_pos += STEP;
    else if (d < -STEP) model_pos -= STEP;
    else                model_pos = tgt;
  endtask

  task automatic slew_tick();
    slk = 1'b1;
    cyc(2);
    slk = 1'b0;
    cyc(2);
    model_slew();
  endtask

  task automatic sample_tick();
    sclk = 1'b1;
    cyc(2);
    sclk = 1'b0;
    cyc(2);
  endtask

  task automatic set_en(input bit v);
    en = v;
    cyc(4);
`ifdef SERVO_DEBOUNCE_EN
    repeat (DBS) sample_tick();
`endif
    cyc(2);
    model_en = v;
  endtask

  task automatic frame_high(output int h);
    h = 0;
    repeat (FRAME) begin
      cyc(1);
      if (pwm === 1'b1) h++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int n;
    en = 1'b0; slk = 1'b0; sclk = 1'b0; desired = '0; count = '0;
    rst = 1'b1;
    #2;
    check("rst_pwm",  {31'd0, pwm},  32'd0);
    check("rst_flag", {31'd0, flag}, 32'd0);
    check("rst_pos",  {12'd0, dut.pos_q}, 32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(3);
    check("flag_idle", {31'd0, flag}, 32'd1);
    frame_high(h);
    check("pwm_disabled", h, 0);

    desired = 20'd80;
`ifdef SERVO_DEBOUNCE_EN
    en = 1'b1;
    cyc(4);
    repeat (DBS - 1) sample_tick();
    en = 1'b0;
    cyc(4);
    sample_tick();
    slew_tick();
    check("db_glitch_pos", {12'd0, dut.pos_q}, model_pos);
    frame_high(h);
    check("db_glitch_pwm", h, 0);
`endif
    set_en(1'b1);

    for (int i = 0; i < 10; i++) begin
      slew_tick();
      check("ramp_pos",  {12'd0, dut.pos_q}, model_pos);
      check("ramp_flag", {31'd0, flag}, (model_pos == model_target()) ? 1 : 0);
    end
    check("pos_80", {12'd0, dut.pos_q}, 32'd80);
    frame_high(h);
    check("width_80", h, BASE + 80);

    desired = 20'd250;
    repeat (20) begin
      slew_tick();
      check("clamp_pos", {12'd0, dut.pos_q}, model_pos);
      check("pos_le_max", {31'd0, (dut.pos_q > 20'(MAXO))}, 32'd0);
    end
    check("pos_max", {12'd0, dut.pos_q}, MAXO);
    check("flag_max", {31'd0, flag}, 32'd1);
    frame_high(h);
    check("width_max", h, BASE + MAXO);

    repeat (6) begin
      desired = 20'($urandom_range(0, 260));
      n = $urandom_range(1, 20);
      repeat (n) begin
        slew_tick();
        exp_q.push_back(20'(model_pos));
        check("rand_pos",  {12'd0, dut.pos_q}, {12'd0, exp_q.pop_front()});
        check("rand_flag", {31'd0, flag}, (model_pos == model_target()) ? 1 : 0);
      end
    end

    desired = 20'd150;
    repeat (3) slew_tick();
    while (count != 28'd5) cyc(1);
    check("pwm_before_rst", {31'd0, pwm}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_pwm",  {31'd0, pwm},  32'd0);
    check("midrst_flag", {31'd0, flag}, 32'd0);
    check("midrst_pos",  {12'd0, dut.pos_q}, 32'd0);
    model_pos = 0;
    model_en  = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    set_en(1'b1);
    desired = 20'd5;
    slew_tick();
    check("small_step", {12'd0, dut.pos_q}, 32'd5);

    desired = 20'd200;
    repeat (5) slew_tick();
    check("move_pos", {12'd0, dut.pos_q}, model_pos);
    set_en(1'b0);
    repeat (3) slew_tick();
    check("frozen_pos", {12'd0, dut.pos_q}, 32'd45);
    frame_high(h);
    check("frozen_pwm", h, 0);
    set_en(1'b1);
    slew_tick();
    check("resume_pos", {12'd0, dut.pos_q}, model_pos);
    check("resume_53",  {12'd0, dut.pos_q}, 32'd53);
    frame_high(h);
    check("resume_width", h, BASE + 53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
